fetch_decode_execute: RTL and testbench
=======================================

Name: fetch_decode_execute

Overview:
- Front three stages of the 5-stage in-order pipeline: Fetch (PC, instruction-memory read), Decode (register file, scoreboard, stall generation), Execute (ALU).
- Outputs feed the Memory stage.
- Branch redirect comes back from Memory; register writes come back from Writeback.

Parameters:
- PC_WIDTH, 16, word-address width of PC.
- IR_WIDTH, 32, instruction width.
- REG_WIDTH, 16, data/register width.
- OPCODE_WIDTH, 8, opcode width.

Ports:
- I_CLOCK  in  1  single clock, all state on rising edge.
- I_LOCK  in  1  synchronous active-low reset (low = reset, high = run).
- O_IMemAddr  out  PC_WIDTH  instruction-memory word address; equals PC register, combinational.
- I_IMemData  in  IR_WIDTH  instruction word, combinational read of O_IMemAddr.
- I_BranchPC  in  PC_WIDTH  redirect target from Memory.
- I_BranchAddrSelect  in  1  redirect strobe; one pulse per branch/jump, taken or not.
- I_WriteBackEnable  in  1  register write strobe.
- I_WriteBackRegIdx  in  4  register write index.
- I_WriteBackData  in  REG_WIDTH  register write data.
- O_LOCK  out  1  I_LOCK delayed three cycles (one per stage).
- O_FetchStall  out  1  Execute output is a fetch/branch bubble.
- O_DepStall  out  1  Execute output is a dependency bubble.
- O_ALUOut  out  REG_WIDTH  ALU result or branch target.
- O_BranchTaken  out  1  branch condition true.
- O_Opcode  out  OPCODE_WIDTH  opcode; 0xFF (NOP) for bubbles.
- O_DestRegIdx  out  4  destination register.

Behaviour:
- IR fields:
  - [31:24] opcode
  - [23:20] dest
  - [19:16] src1
  - [11:8] src2
  - [15:0] imm (16-bit, no extension needed)
- Opcodes:
  - 0x00 ADD d=s1+s2
  - 0x01 ADDI d=s1+imm
  - 0x02 AND d=s1&s2
  - 0x03 ANDI d=s1&imm
  - 0x04 MOV d=s1
  - 0x05 MOVI d=imm
  - 0x06 LDW ALUOut=s1+imm (address), writes d
  - 0x08 BRZ target=PC+1+imm, taken if s1==0
  - 0x09 JMP target=s1, always taken
  - 0xFF NOP
  - Any other opcode is treated as NOP.
- Arithmetic is modulo 2^REG_WIDTH.
- Reset (I_LOCK low at edge), for every stage:
  - PC=0; all stage registers cleared.
  - Outputs: O_LOCK=0, O_Opcode=0xFF, O_ALUOut=0, O_DestRegIdx=0, O_BranchTaken=0, O_FetchStall=0, O_DepStall=0.
  - All 16 registers =0; scoreboard cleared; branch-stall flag cleared.
  - Reset mid-operation discards all in-flight instructions.
- Fetch, priority top-down:
  - I_BranchAddrSelect: PC<=I_BranchPC; FD gets a bubble with FetchStall=1.
  - Branch-stall flag set: PC holds; FD gets a bubble with FetchStall=1.
  - DepStallSignal: PC and FD both hold, so the instruction is replayed.
  - Otherwise: FD.IR<=I_IMemData; FD.PC<=PC+1; PC<=PC+1. PC wraps at 2^PC_WIDTH.
- Decode:
  - Sources used by each opcode:
    - ADD, AND: s1 and s2.
    - ADDI, ANDI, MOV, LDW, BRZ, JMP: s1.
    - MOVI: none.
  - DepStallSignal (combinational) = valid FD instruction AND (any used source busy OR dest busy for writing ops).
  - On DepStallSignal: DE gets a bubble with DepStall=1.
  - On issue of a writing op (0x00-0x06): busy[dest]<=1.
  - I_WriteBackEnable: reg[idx]<=data; busy[idx]<=0. If issue sets the same idx in the same cycle, set wins.
  - Issuing BRZ/JMP sets the branch-stall flag. I_BranchAddrSelect clears it; clear has priority over set.
  - O_BranchStallSignal = the flag.
  - Bubbles carry no scoreboard effect.
- Execute:
  - Registered ALU; bubbles pass through as opcode 0xFF with ALUOut=0.
  - Stall flags propagate unchanged.
- Latency: an instruction presented at O_IMemAddr at edge n appears on Execute outputs after edge n+3.
- Branch resolution is external: the redirect arrives when Memory pulses I_BranchAddrSelect. No speculative fetch past a branch.

Optional Feature:
- Macro WB_BYPASS_EN.
- When defined:
  - Decode operand reads return I_WriteBackData when I_WriteBackEnable and the index match.
  - The busy test ignores an index being cleared that same cycle.
  - A dependent instruction issues in the writeback cycle.
- When undefined:
  - Reads see the pre-write value.
  - The dependent instruction stalls one extra cycle.

Test Plan:
- Reset: hold I_LOCK low 3 cycles, then raise -> O_IMemAddr=0,1,2,... on successive cycles; O_LOCK rises three cycles after I_LOCK; O_Opcode=0xFF until the first instruction arrives.
- Independent ops: MOVI r1,5; MOVI r2,7 -> O_ALUOut=0x0005 then 0x0007, O_DestRegIdx=1 then 2, no stall flags.
- RAW stall: MOVI r1,3; ADDI r2,r1,4; Writeback of r1=3 returned four cycles later -> ADDI held in Decode while r1 busy. Execute shows DepStall=1 bubbles, then O_ALUOut=7. Bubble count is one fewer with WB_BYPASS_EN.
- Branch: BRZ r0,+4 at PC 2 with r0=0 -> O_BranchTaken=1, O_ALUOut=7, fetch frozen with FetchStall bubbles. Pulse I_BranchAddrSelect with I_BranchPC=7 -> next O_IMemAddr=7.
- Simultaneous events: writeback to r3 in the same cycle an ADDI r3 issues -> busy[3] remains 1, reg r3 holds the writeback data. Mid-run I_LOCK low -> all outputs return to reset values next edge.

Source files
------------

// File: rtl/fetch_decode_execute.sv
// fetch_decode_execute: Fetch, Decode and Execute stages of a 5-stage in-order pipeline.
//   Fetch   : PC register, instruction-memory address, FD pipeline register.
//   Decode  : 16-entry register file, busy scoreboard, dependency/branch stalls, DE register.
//   Execute : registered ALU driving the Memory stage.
// Optional build macro: WB_BYPASS_EN (writeback data forwarded into Decode operand reads).
// Ports:
//   I_CLOCK, I_LOCK                      clock, synchronous active-low reset
//   O_IMemAddr / I_IMemData              instruction-memory address and read data
//   I_BranchPC, I_BranchAddrSelect       branch redirect from Memory
//   I_WriteBack{Enable,RegIdx,Data}      register write from Writeback
//   O_LOCK                               I_LOCK delayed through the three stages
//   O_FetchStall, O_DepStall             bubble type of the Execute output
//   O_ALUOut, O_BranchTaken, O_Opcode,
//   O_DestRegIdx                         Execute results
//   O_BranchStallSignal                  branch-stall flag (fetch frozen until redirect)
module fetch_decode_execute #(
  parameter int unsigned PC_WIDTH     = 16,
  parameter int unsigned IR_WIDTH     = 32,
  parameter int unsigned REG_WIDTH    = 16,
  parameter int unsigned OPCODE_WIDTH = 8
) (
  input  logic                    I_CLOCK,
  input  logic                    I_LOCK,
  output logic [PC_WIDTH-1:0]     O_IMemAddr,
  input  logic [IR_WIDTH-1:0]     I_IMemData,
  input  logic [PC_WIDTH-1:0]     I_BranchPC,
  input  logic                    I_BranchAddrSelect,
  input  logic                    I_WriteBackEnable,
  input  logic [3:0]              I_WriteBackRegIdx,
  input  logic [REG_WIDTH-1:0]    I_WriteBackData,
  output logic                    O_LOCK,
  output logic                    O_FetchStall,
  output logic                    O_DepStall,
  output logic [REG_WIDTH-1:0]    O_ALUOut,
  output logic                    O_BranchTaken,
  output logic [OPCODE_WIDTH-1:0] O_Opcode,
  output logic [3:0]              O_DestRegIdx,
  output logic                    O_BranchStallSignal
);

  localparam int unsigned NUM_REGS = 16;
  localparam int unsigned IMM_WIDTH = 16;

  localparam logic [OPCODE_WIDTH-1:0] OP_ADD  = OPCODE_WIDTH'(8'h00);
  localparam logic [OPCODE_WIDTH-1:0] OP_ADDI = OPCODE_WIDTH'(8'h01);
  localparam logic [OPCODE_WIDTH-1:0] OP_AND  = OPCODE_WIDTH'(8'h02);
  localparam logic [OPCODE_WIDTH-1:0] OP_ANDI = OPCODE_WIDTH'(8'h03);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOV  = OPCODE_WIDTH'(8'h04);
  localparam logic [OPCODE_WIDTH-1:0] OP_MOVI = OPCODE_WIDTH'(8'h05);
  localparam logic [OPCODE_WIDTH-1:0] OP_LDW  = OPCODE_WIDTH'(8'h06);
  localparam logic [OPCODE_WIDTH-1:0] OP_BRZ  = OPCODE_WIDTH'(8'h08);
  localparam logic [OPCODE_WIDTH-1:0] OP_JMP  = OPCODE_WIDTH'(8'h09);
  localparam logic [OPCODE_WIDTH-1:0] OP_NOP  = {OPCODE_WIDTH{1'b1}};

  // ---------------------------------------------------------------- state
  logic [PC_WIDTH-1:0]              r_pc;
  logic                             r_lock_f;
  logic                             r_fd_valid;
  logic                             r_fd_fstall;
  logic [IR_WIDTH-1:0]              r_fd_ir;
  logic [PC_WIDTH-1:0]              r_fd_pc1;

  logic [NUM_REGS-1:0][REG_WIDTH-1:0] r_regs;
  logic [NUM_REGS-1:0]              r_busy;
  logic                             r_branch_stall;
  logic                             r_lock_d;
  logic [OPCODE_WIDTH-1:0]          r_de_op;
  logic [3:0]                       r_de_dest;
  logic [REG_WIDTH-1:0]             r_de_a;
  logic [REG_WIDTH-1:0]             r_de_b;
  logic [PC_WIDTH-1:0]              r_de_pc1;
  logic                             r_de_fstall;
  logic                             r_de_dstall;

  logic                             r_lock_e;
  logic [OPCODE_WIDTH-1:0]          r_ex_op;
  logic [3:0]                       r_ex_dest;
  logic [REG_WIDTH-1:0]             r_ex_alu;
  logic                             r_ex_taken;
  logic                             r_ex_fstall;
  logic                             r_ex_dstall;

  // ---------------------------------------------------------------- decode fields
  logic [OPCODE_WIDTH-1:0] w_fd_op;
  logic [3:0]              w_dest;
  logic [3:0]              w_src1;
  logic [3:0]              w_src2;
  logic [IMM_WIDTH-1:0]    w_imm;

  assign w_fd_op = r_fd_ir[IR_WIDTH-1 -: OPCODE_WIDTH];
  assign w_dest  = r_fd_ir[23:20];
  assign w_src1  = r_fd_ir[19:16];
  assign w_src2  = r_fd_ir[11:8];
  assign w_imm   = r_fd_ir[15:0];

  // Operand usage per opcode; unknown opcodes behave as NOP.
  logic w_uses_s1;
  logic w_uses_s2;
  logic w_writes;
  logic w_is_branch;
  logic w_known;

  always_comb begin
    w_uses_s1   = 1'b0;
    w_uses_s2   = 1'b0;
    w_writes    = 1'b0;
    w_is_branch = 1'b0;
    w_known     = 1'b1;
    case (w_fd_op)
      OP_ADD, OP_AND: begin
        w_uses_s1 = 1'b1;
        w_uses_s2 = 1'b1;
        w_writes  = 1'b1;
      end
      OP_ADDI, OP_ANDI, OP_MOV, OP_LDW: begin
        w_uses_s1 = 1'b1;
        w_writes  = 1'b1;
      end
      OP_MOVI: w_writes = 1'b1;
      OP_BRZ, OP_JMP: begin
        w_uses_s1   = 1'b1;
        w_is_branch = 1'b1;
      end
      default: w_known = 1'b0;
    endcase
  end

  // Scoreboard view and operand reads, optionally forwarding the writeback port.
  logic [NUM_REGS-1:0]  w_busy_eff;
  logic [REG_WIDTH-1:0] w_s1_val;
  logic [REG_WIDTH-1:0] w_s2_val;

  always_comb begin
    w_busy_eff = r_busy;
    w_s1_val   = r_regs[w_src1];
    w_s2_val   = r_regs[w_src2];
`ifdef WB_BYPASS_EN
    if (I_WriteBackEnable) begin
      w_busy_eff[I_WriteBackRegIdx] = 1'b0;
      if (I_WriteBackRegIdx == w_src1) w_s1_val = I_WriteBackData;
      if (I_WriteBackRegIdx == w_src2) w_s2_val = I_WriteBackData;
    end
`endif
  end

  logic w_dep_stall;
  logic w_issue;
  logic w_issue_write;
  logic w_issue_branch;

  assign w_dep_stall    = r_fd_valid & ((w_uses_s1 & w_busy_eff[w_src1]) |
                                        (w_uses_s2 & w_busy_eff[w_src2]) |
                                        (w_writes  & w_busy_eff[w_dest]));
  assign w_issue        = r_fd_valid & ~w_dep_stall;
  assign w_issue_write  = w_issue & w_writes;
  assign w_issue_branch = w_issue & w_is_branch;

  // ---------------------------------------------------------------- fetch
  // A branch leaving Decode freezes the PC in the same edge so nothing past it is fetched.
  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      r_pc        <= '0;
      r_lock_f    <= 1'b0;
      r_fd_valid  <= 1'b0;
      r_fd_fstall <= 1'b0;
      r_fd_ir     <= '0;
      r_fd_pc1    <= '0;
    end else begin
      r_lock_f <= I_LOCK;
      if (I_BranchAddrSelect) begin
        r_pc        <= I_BranchPC;
        r_fd_valid  <= 1'b0;
        r_fd_fstall <= 1'b1;
      end else if (r_branch_stall || w_issue_branch) begin
        r_fd_valid  <= 1'b0;
        r_fd_fstall <= 1'b1;
      end else if (!w_dep_stall) begin
        r_fd_ir     <= I_IMemData;
        r_fd_pc1    <= r_pc + PC_WIDTH'(1);
        r_pc        <= r_pc + PC_WIDTH'(1);
        r_fd_valid  <= 1'b1;
        r_fd_fstall <= 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------- decode
  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      r_regs         <= '0;
      r_busy         <= '0;
      r_branch_stall <= 1'b0;
      r_lock_d       <= 1'b0;
      r_de_op        <= OP_NOP;
      r_de_dest      <= '0;
      r_de_a         <= '0;
      r_de_b         <= '0;
      r_de_pc1       <= '0;
      r_de_fstall    <= 1'b0;
      r_de_dstall    <= 1'b0;
    end else begin
      r_lock_d <= r_lock_f;

      if (I_WriteBackEnable) begin
        r_regs[I_WriteBackRegIdx] <= I_WriteBackData;
        r_busy[I_WriteBackRegIdx] <= 1'b0;
      end
      // Issue after writeback so a same-index set overrides the clear.
      if (w_issue_write) r_busy[w_dest] <= 1'b1;

      if (I_BranchAddrSelect)  r_branch_stall <= 1'b0;
      else if (w_issue_branch) r_branch_stall <= 1'b1;

      if (w_issue) begin
        r_de_op     <= w_known ? w_fd_op : OP_NOP;
        r_de_dest   <= w_writes ? w_dest : 4'd0;
        r_de_a      <= w_s1_val;
        r_de_b      <= w_uses_s2 ? w_s2_val : REG_WIDTH'(w_imm);
        r_de_pc1    <= r_fd_pc1;
        r_de_fstall <= 1'b0;
        r_de_dstall <= 1'b0;
      end else begin
        r_de_op     <= OP_NOP;
        r_de_dest   <= '0;
        r_de_a      <= '0;
        r_de_b      <= '0;
        r_de_pc1    <= '0;
        r_de_fstall <= r_fd_fstall & ~r_fd_valid;
        r_de_dstall <= w_dep_stall;
      end
    end
  end

  // ---------------------------------------------------------------- execute
  logic [REG_WIDTH-1:0] w_alu;
  logic                 w_taken;

  always_comb begin
    w_alu   = '0;
    w_taken = 1'b0;
    case (r_de_op)
      OP_ADD, OP_ADDI, OP_LDW: w_alu = r_de_a + r_de_b;
      OP_AND, OP_ANDI:         w_alu = r_de_a & r_de_b;
      OP_MOV:                  w_alu = r_de_a;
      OP_MOVI:                 w_alu = r_de_b;
      OP_BRZ: begin
        w_alu   = REG_WIDTH'(r_de_pc1) + r_de_b;
        w_taken = (r_de_a == '0);
      end
      OP_JMP: begin
        w_alu   = r_de_a;
        w_taken = 1'b1;
      end
      default: w_alu = '0;
    endcase
  end

  always_ff @(posedge I_CLOCK) begin
    if (!I_LOCK) begin
      r_lock_e    <= 1'b0;
      r_ex_op     <= OP_NOP;
      r_ex_dest   <= '0;
      r_ex_alu    <= '0;
      r_ex_taken  <= 1'b0;
      r_ex_fstall <= 1'b0;
      r_ex_dstall <= 1'b0;
    end else begin
      r_lock_e    <= r_lock_d;
      r_ex_op     <= r_de_op;
      r_ex_dest   <= r_de_dest;
      r_ex_alu    <= w_alu;
      r_ex_taken  <= w_taken;
      r_ex_fstall <= r_de_fstall;
      r_ex_dstall <= r_de_dstall;
    end
  end

  // ---------------------------------------------------------------- outputs
  assign O_IMemAddr          = r_pc;
  assign O_LOCK              = r_lock_e;
  assign O_Opcode            = r_ex_op;
  assign O_DestRegIdx        = r_ex_dest;
  assign O_ALUOut            = r_ex_alu;
  assign O_BranchTaken       = r_ex_taken;
  assign O_FetchStall        = r_ex_fstall;
  assign O_DepStall          = r_ex_dstall;
  assign O_BranchStallSignal = r_branch_stall;

endmodule

// File: tb/tb_fetch_decode_execute.sv
// Directed bench for fetch_decode_execute: reset, independent ops, RAW stall,
// branch freeze/redirect, simultaneous writeback+issue, mid-run reset.
module tb_fetch_decode_execute;

`ifdef WB_BYPASS_EN
  localparam int DEP_BUBBLES = 2;
`else
  localparam int DEP_BUBBLES = 3;
`endif

  logic        clk = 1'b0;
  logic        lock;
  logic [15:0] addr;
  logic [31:0] imem_data;
  logic [15:0] bpc;
  logic        sel;
  logic        wbe;
  logic [3:0]  wbi;
  logic [15:0] wbd;
  logic        o_lock;
  logic        fstall;
  logic        dstall;
  logic [15:0] alu;
  logic        taken;
  logic [7:0]  opcode;
  logic [3:0]  dest;
  logic        bss;

  logic [31:0] imem [64];
  assign imem_data = imem[addr[5:0]];

  always #5 clk = ~clk;

  fetch_decode_execute dut (
    .I_CLOCK             (clk),
    .I_LOCK              (lock),
    .O_IMemAddr          (addr),
    .I_IMemData          (imem_data),
    .I_BranchPC          (bpc),
    .I_BranchAddrSelect  (sel),
    .I_WriteBackEnable   (wbe),
    .I_WriteBackRegIdx   (wbi),
    .I_WriteBackData     (wbd),
    .O_LOCK              (o_lock),
    .O_FetchStall        (fstall),
    .O_DepStall          (dstall),
    .O_ALUOut            (alu),
    .O_BranchTaken       (taken),
    .O_Opcode            (opcode),
    .O_DestRegIdx        (dest),
    .O_BranchStallSignal (bss)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_ex(input string tag, input logic [7:0] e_op, input logic [15:0] e_alu,
                        input logic [3:0] e_dest, input logic e_taken,
                        input logic e_fs, input logic e_ds);
    chk({tag, ".op"},    32'(opcode), 32'(e_op));
    chk({tag, ".alu"},   32'(alu),    32'(e_alu));
    chk({tag, ".dest"},  32'(dest),   32'(e_dest));
    chk({tag, ".taken"}, 32'(taken),  32'(e_taken));
    chk({tag, ".fs"},    32'(fstall), 32'(e_fs));
    chk({tag, ".ds"},    32'(dstall), 32'(e_ds));
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".addr"}, 32'(addr),   32'd0);
    chk({tag, ".lock"}, 32'(o_lock), 32'd0);
    chk({tag, ".bss"},  32'(bss),    32'd0);
    chk_ex(tag, 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_imem();
    for (int i = 0; i < 64; i++) imem[i] = 32'hFF00_0000;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    lock = 1'b0; sel = 1'b0; bpc = '0; wbe = 1'b0; wbi = '0; wbd = '0;

    // ---- Phase A: reset release, independent MOVIs
    clear_imem();
    imem[0] = 32'h0510_0005;            // MOVI r1,5
    imem[1] = 32'h0520_0007;            // MOVI r2,7
    repeat (3) step();
    chk_reset("A.rst");
    lock = 1'b1;
    step();                             // E1
    chk("A.addr1", 32'(addr), 32'd1);
    chk("A.lock1", 32'(o_lock), 32'd0);
    step();                             // E2
    chk("A.addr2", 32'(addr), 32'd2);
    chk("A.lock2", 32'(o_lock), 32'd0);
    chk("A.op2", 32'(opcode), 32'hFF);
    step();                             // E3
    chk("A.lock3", 32'(o_lock), 32'd1);
    chk_ex("A.movi1", 8'h05, 16'h0005, 4'd1, 1'b0, 1'b0, 1'b0);
    step();                             // E4
    chk_ex("A.movi2", 8'h05, 16'h0007, 4'd2, 1'b0, 1'b0, 1'b0);
    step();                             // E5
    chk_ex("A.nop", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b0);

    // ---- Phase B: RAW stall on r1
    lock = 1'b0;
    clear_imem();
    imem[0] = 32'h0510_0003;            // MOVI r1,3
    imem[1] = 32'h0121_0004;            // ADDI r2,r1,4
    repeat (2) step();
    chk_reset("B.rst");
    lock = 1'b1;
    repeat (3) step();                  // E3
    chk_ex("B.movi", 8'h05, 16'h0003, 4'd1, 1'b0, 1'b0, 1'b0);
    chk("B.pc_hold3", 32'(addr), 32'd2);
    step();                             // E4
    chk_ex("B.dep1", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    chk("B.pc_hold4", 32'(addr), 32'd2);
    wbe = 1'b1; wbi = 4'd1; wbd = 16'h0003;
    for (int k = 2; k <= DEP_BUBBLES; k++) begin
      step();
      if (k == 2) wbe = 1'b0;
      chk_ex("B.depN", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    end
    step();
    chk_ex("B.addi", 8'h01, 16'h0007, 4'd2, 1'b0, 1'b0, 1'b0);

    // ---- Phase C: BRZ r0,+4 at PC 2, redirect to 7
    lock = 1'b0;
    clear_imem();
    imem[2] = 32'h0800_0004;            // BRZ r0,+4
    imem[3] = 32'h0550_0033;            // MOVI r5,0x33 (must never execute)
    imem[7] = 32'h0560_0066;            // MOVI r6,0x66
    repeat (2) step();
    chk_reset("C.rst");
    lock = 1'b1;
    repeat (3) step();                  // E3: BRZ in FD
    chk("C.addr3", 32'(addr), 32'd3);
    step();                             // E4: BRZ issued, fetch frozen
    chk("C.addr4", 32'(addr), 32'd3);
    chk("C.bss4", 32'(bss), 32'd1);
    step();                             // E5
    chk_ex("C.brz", 8'h08, 16'h0007, 4'd0, 1'b1, 1'b0, 1'b0);
    chk("C.addr5", 32'(addr), 32'd3);
    sel = 1'b1; bpc = 16'd7;
    step();                             // E6: redirect
    sel = 1'b0;
    chk("C.addr6", 32'(addr), 32'd7);
    chk("C.bss6", 32'(bss), 32'd0);
    chk_ex("C.fs1", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    step();                             // E7
    chk("C.addr7", 32'(addr), 32'd8);
    chk_ex("C.fs2", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    step();                             // E8
    chk_ex("C.fs3", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b1, 1'b0);
    step();                             // E9
    chk_ex("C.target", 8'h05, 16'h0066, 4'd6, 1'b0, 1'b0, 1'b0);

    // ---- Phase D: writeback r3 while ADDI r3 issues, then mid-run reset
    lock = 1'b0;
    clear_imem();
    imem[0] = 32'h0130_0001;            // ADDI r3,r0,1
    imem[1] = 32'h0443_0000;            // MOV r4,r3
    repeat (2) step();
    chk_reset("D.rst");
    lock = 1'b1;
    step();                             // E1: ADDI in FD
    wbe = 1'b1; wbi = 4'd3; wbd = 16'hABCD;
    step();                             // E2: ADDI issues with writeback to r3
    wbe = 1'b0;
    step();                             // E3
    chk_ex("D.addi", 8'h01, 16'h0001, 4'd3, 1'b0, 1'b0, 1'b0);
    step();                             // E4: MOV still blocked -> busy[3] kept
    chk_ex("D.busy_kept", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    wbe = 1'b1; wbi = 4'd3; wbd = 16'h0042;
    for (int k = 2; k <= DEP_BUBBLES; k++) begin
      step();
      if (k == 2) wbe = 1'b0;
      chk_ex("D.depN", 8'hFF, 16'h0000, 4'd0, 1'b0, 1'b0, 1'b1);
    end
    step();
    chk_ex("D.mov", 8'h04, 16'h0042, 4'd4, 1'b0, 1'b0, 1'b0);
    chk("D.lock_run", 32'(o_lock), 32'd1);
    lock = 1'b0;
    step();
    chk_reset("D.midrst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
